// File: rtl/demux_merge_rr4.sv
// Four-to-one round-robin merge with one registered output stage.
// out_sel tags each word with its source channel for a downstream demux.
`timescale 1ns/1ps
module demux_merge_rr4 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   xfer_count
);

  logic [3:0][WIDTH-1:0] lane;
  logic [1:0]            last, gsel;
  logic                  found, load, xfer;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Scan starts just after the last winner; the first valid channel wins.
  always_comb begin : p_arb
    logic [1:0] idx;
    idx   = '0;
    found = 1'b0;
    gsel  = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gsel  = idx;
      end
    end
  end

  assign load     = !out_valid || out_ready;
  assign xfer     = reset && load && found;
  assign in_ready = xfer ? (4'b0001 << gsel) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      xfer_count <= '0;
      last       <= 2'd3;
    end else begin
      if (out_valid && out_ready && xfer_count != {CNT_W{1'b1}})
        xfer_count <= xfer_count + 1'b1;
      if (load) begin
        if (found) begin
          // only the granted lane is sampled, so X on idle lanes never lands here
          out_data  <= lane[gsel];
          out_sel   <= gsel;
          out_valid <= 1'b1;
          last      <= gsel;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_merge_rr4.sv
// Directed + randomized bench for demux_merge_rr4 against a rule-level model.
`timescale 1ns/1ps
module tb_demux_merge_rr4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            in_valid;
  logic [3:0][WIDTH-1:0] lanes;
  logic [4*WIDTH-1:0]    in_data;
  logic [3:0]            in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [1:0]            out_sel;
  logic                  out_ready;
  logic [CNT_W-1:0]      xfer_count;

  assign in_data = lanes;

  demux_merge_rr4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state
  bit       m_valid;
  int       m_data, m_sel, m_last, m_cnt;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_sel = 0; m_last = 3; m_cnt = 0;
  endtask

  // Winner is the valid channel nearest after the last winner, going round.
  function automatic int pick(input logic [3:0] v, input int last);
    int best = -1, bestd = 9;
    for (int i = 0; i < 4; i++)
      if (v[i] === 1'b1 && ((i - last + 7) % 4) < bestd) begin
        bestd = (i - last + 7) % 4;
        best  = i;
      end
    return best;
  endfunction

  // Inputs already set at a negedge; check, clock once, advance the model.
  task automatic cycle();
    int w;
    bit ld;
    logic [3:0] er;
    #1;
    ld = !m_valid || out_ready;
    w  = pick(in_valid, m_last);
    er = (reset && ld && w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_sel", 32'(out_sel), 32'(m_sel));
    end
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      if (m_valid && out_ready && m_cnt < CMAX) m_cnt++;
      if (ld) begin
        if (w >= 0) begin
          m_data = int'(lanes[w]); m_sel = w; m_valid = 1; m_last = w;
        end else m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_seq_data();
    for (int i = 0; i < 4; i++) lanes[i] = 8'hA0 + 8'(i);
  endtask

  initial begin
    reset = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; set_seq_data();
    @(posedge clk); @(negedge clk);
    model_reset();

    // reset hold: nothing accepted, outputs cleared
    cycle(); cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(xfer_count), 32'd0);

    // full round robin
    reset = 1'b1;
    for (int n = 0; n < 6; n++) cycle();
    chk("rr_cnt5", 32'(xfer_count), 32'd5);

    // backpressure: load 0x55 from channel 2 and stall
    in_valid = 4'b0000; cycle();
    in_valid = 4'b0100; lanes[2] = 8'h55; out_ready = 1'b0; cycle();
    in_valid = 4'b1111;
    for (int n = 0; n < 3; n++) cycle();
    chk("bp_data", 32'(out_data), 32'h55);
    chk("bp_sel", 32'(out_sel), 32'd2);
    out_ready = 1'b1; cycle();

    // sparse and wrap
    in_valid = 4'b1000; cycle();
    in_valid = 4'b0010; cycle();
    in_valid = 4'b1001; cycle();
    chk("wrap_sel3", 32'(out_sel), 32'd3);

    // mid-operation reset while stalled
    in_valid = 4'b0001; out_ready = 1'b0; cycle();
    reset = 1'b0; cycle();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_cnt", 32'(xfer_count), 32'd0);
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; set_seq_data(); cycle();
    chk("mrst_sel0", 32'(out_sel), 32'd0);

    // saturation
    for (int n = 0; n < 22; n++) cycle();
    chk("sat_cnt", 32'(xfer_count), 32'(CMAX));

    // randomized traffic; idle lanes carry X
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) != 0);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++)
        lanes[i] = in_valid[i] ? 8'($urandom) : 'x;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
